// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter for a single-port word memory
// Purpose: grants one of two requesters per cycle (zero-wait when uncontended),
//   supports locked ownership bursts, round-robin or fixed priority, and a
//   per-requester wait counter that forces a win after MAX_WAIT denied cycles.
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   reqN/weN/lockN         request, write (1) / read (0), hold ownership
//   addrN, wdataN          word address and write data of requester N
//   gntN                   combinational grant for this cycle
//   rvalidN, rdataN        read response, one cycle after a granted read
//   mem_we/waddr/raddr     memory control; addresses hold when nobody is granted
//   mem_wdata, mem_rdata   memory write data / synchronous read data

module mem_arbiter #(
  parameter int MAX_WAIT  = 8,
  parameter int PRIO_MODE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic        lock0,
  input  logic        lock1,
  input  logic [9:0]  addr0,
  input  logic [9:0]  addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic        mem_we,
  output logic [9:0]  mem_waddr,
  output logic [9:0]  mem_raddr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_OWN0, ST_OWN1} state_t;

  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_wait0;
  logic [3:0]  r_wait1;
  logic        r_last;      // 1 = requester 1 was granted most recently
  logic [9:0]  r_addr;
  logic [15:0] r_wdata;
  logic        r_rvalid0;
  logic        r_rvalid1;

  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_starve0;
  logic        w_starve1;
  logic [9:0]  w_addr;
  logic [15:0] w_wdata;

  // A starving requester only matters in a cycle where it is actually asking.
  assign w_starve0 = req0 & (r_wait0 == LP_MAX_WAIT);
  assign w_starve1 = req1 & (r_wait1 == LP_MAX_WAIT);

  // Grant decision and next state. Grants are gated by rst so that the memory
  // interface shows its reset values while reset is held.
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_state_nxt = ST_IDLE;
    if (rst) begin
      if (w_starve0) begin
        w_gnt0 = 1'b1;               // requester 0 also wins a double starve
      end else if (w_starve1) begin
        w_gnt1 = 1'b1;
      end else if (r_state == ST_OWN0 && req0 && lock0) begin
        w_gnt0 = 1'b1;
      end else if (r_state == ST_OWN1 && req1 && lock1) begin
        w_gnt1 = 1'b1;
      end else if (req0 && req1) begin
        // Lock dropped or no owner: contention resolved by IDLE rules.
        if (PRIO_MODE != 0 || r_last) begin
          w_gnt0 = 1'b1;
        end else begin
          w_gnt1 = 1'b1;
        end
      end else if (req0) begin
        w_gnt0 = 1'b1;
      end else if (req1) begin
        w_gnt1 = 1'b1;
      end
    end
    // A forced win breaks the other side's lock; ownership follows the winner.
    if (w_gnt0 && lock0) begin
      w_state_nxt = ST_OWN0;
    end else if (w_gnt1 && lock1) begin
      w_state_nxt = ST_OWN1;
    end
  end

  assign w_addr  = w_gnt0 ? addr0  : (w_gnt1 ? addr1  : r_addr);
  assign w_wdata = w_gnt0 ? wdata0 : (w_gnt1 ? wdata1 : r_wdata);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_wait0   <= 4'd0;
      r_wait1   <= 4'd0;
      r_last    <= 1'b1;
      r_addr    <= 10'd0;
      r_wdata   <= 16'd0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr;
      r_wdata   <= w_wdata;
      r_rvalid0 <= w_gnt0 & ~we0;
      r_rvalid1 <= w_gnt1 & ~we1;
      if (w_gnt1) begin
        r_last <= 1'b1;
      end else if (w_gnt0) begin
        r_last <= 1'b0;
      end
      if (!req0 || w_gnt0) begin
        r_wait0 <= 4'd0;
      end else if (r_wait0 != LP_MAX_WAIT) begin
        r_wait0 <= r_wait0 + 4'd1;
      end
      if (!req1 || w_gnt1) begin
        r_wait1 <= 4'd0;
      end else if (r_wait1 != LP_MAX_WAIT) begin
        r_wait1 <= r_wait1 + 4'd1;
      end
    end
  end

  assign gnt0      = w_gnt0;
  assign gnt1      = w_gnt1;
  assign rvalid0   = r_rvalid0;
  assign rvalid1   = r_rvalid1;
  assign rdata0    = mem_rdata;
  assign rdata1    = mem_rdata;
  assign mem_we    = (w_gnt0 & we0) | (w_gnt1 & we1);
  assign mem_waddr = w_addr;
  assign mem_raddr = w_addr;
  assign mem_wdata = w_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter

module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [9:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;

  // index 0: MAX_WAIT=8 round-robin, 1: MAX_WAIT=3 round-robin, 2: MAX_WAIT=4 fixed
  logic [2:0]  g0, g1, rv0, rv1, mwe;
  logic [15:0] rd0 [3];
  logic [15:0] rd1 [3];
  logic [15:0] mwd [3];
  logic [15:0] mrd [3];
  logic [9:0]  mwa [3];
  logic [9:0]  mra [3];

  for (genvar k = 0; k < 3; k++) begin : g_dut
    mem_arbiter #(
      .MAX_WAIT ((k == 0) ? 8 : ((k == 1) ? 3 : 4)),
      .PRIO_MODE((k == 2) ? 1 : 0)
    ) u_dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .lock0(lock0), .lock1(lock1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(g0[k]), .gnt1(g1[k]), .rvalid0(rv0[k]), .rvalid1(rv1[k]),
      .rdata0(rd0[k]), .rdata1(rd1[k]),
      .mem_we(mwe[k]), .mem_waddr(mwa[k]), .mem_raddr(mra[k]),
      .mem_wdata(mwd[k]), .mem_rdata(mrd[k])
    );
  end

  int cur = 0;          // instance under test
  int nchk = 0;
  int nfail = 0;
  bit sb_en = 1'b0;
  bit mem_ready = 1'b0;

  bit [15:0] mem [1024];      // environment memory, driven by the DUT
  bit [15:0] exp_mem [1024];  // bench's own view of memory contents

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [9:0]  ea;

  // Synchronous-read memory; only the instance under test may write.
  always @(posedge clk) begin
    if (!mem_ready) begin
      mem[5]    <= 16'h1234;
      mem_ready <= 1'b1;
    end else begin
      for (int k = 0; k < 3; k++) mrd[k] <= mem[mra[k]];
      if (mwe[cur]) mem[mwa[cur]] <= mwd[cur];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: a granted read pushes its expected data; exactly one cycle later
  // the matching rvalid must be high with that data, otherwise rvalid stays low.
  always @(posedge clk) begin
    #1;
    if (sb_en) begin
      if (q0.size() > 0) begin
        chk("rvalid0", 32'(rv0[cur]), 32'd1);
        chk("rdata0", 32'(rd0[cur]), 32'(q0.pop_front()));
      end else begin
        chk("rvalid0_idle", 32'(rv0[cur]), 32'd0);
      end
      if (q1.size() > 0) begin
        chk("rvalid1", 32'(rv1[cur]), 32'd1);
        chk("rdata1", 32'(rd1[cur]), 32'(q1.pop_front()));
      end else begin
        chk("rvalid1_idle", 32'(rv1[cur]), 32'd0);
      end
    end
  end

  typedef struct {
    int          dut;
    logic [5:0]  ctl;   // {req0, req1, we0, we1, lock0, lock1}
    logic [9:0]  a0, a1;
    logic [15:0] d0, d1;
    logic [1:0]  eg;    // {gnt0, gnt1} expected
    bit          rb;    // reset before this vector
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int dut, input logic [5:0] ctl,
                              input logic [9:0] a0, input logic [9:0] a1,
                              input logic [15:0] d0, input logic [15:0] d1,
                              input logic [1:0] eg, input bit rb);
    vec_t v;
    v.dut = dut; v.ctl = ctl; v.a0 = a0; v.a1 = a1;
    v.d0 = d0; v.d1 = d1; v.eg = eg; v.rb = rb;
    return v;
  endfunction

  task automatic clear_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    ea = '0;
  endtask

  task automatic apply(input vec_t v);
    logic e0, e1, ew;
    @(negedge clk);
    cur = v.dut;
    {req0, req1, we0, we1, lock0, lock1} = v.ctl;
    addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
    e0 = v.eg[1];
    e1 = v.eg[0];
    #4;
    chk("gnt0", 32'(g0[cur]), 32'(e0));
    chk("gnt1", 32'(g1[cur]), 32'(e1));
    ew = (e0 & v.ctl[3]) | (e1 & v.ctl[2]);
    chk("mem_we", 32'(mwe[cur]), 32'(ew));
    if (e0) ea = v.a0;
    else if (e1) ea = v.a1;
    chk("mem_waddr", 32'(mwa[cur]), 32'(ea));
    chk("mem_raddr", 32'(mra[cur]), 32'(ea));
    if (e0) chk("mem_wdata", 32'(mwd[cur]), 32'(v.d0));
    if (e1) chk("mem_wdata", 32'(mwd[cur]), 32'(v.d1));
    if (e0 && v.ctl[3]) exp_mem[v.a0] = v.d0;
    if (e1 && v.ctl[2]) exp_mem[v.a1] = v.d1;
    if (e0 && !v.ctl[3]) q0.push_back(exp_mem[v.a0]);
    if (e1 && !v.ctl[2]) q1.push_back(exp_mem[v.a1]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    exp_mem[5] = 16'h1234;
    rst = 1'b0;
    clear_inputs();
    req0 = 1; req1 = 1; we0 = 1; addr0 = 10'h155; addr1 = 10'h2AA; wdata0 = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    chk("rst_gnt0", 32'(g0[0]), 32'd0);
    chk("rst_gnt1", 32'(g1[0]), 32'd0);
    chk("rst_rvalid", 32'({rv0[0], rv1[0]}), 32'd0);
    chk("rst_mem_we", 32'(mwe[0]), 32'd0);
    chk("rst_waddr", 32'(mwa[0]), 32'd0);
    chk("rst_raddr", 32'(mra[0]), 32'd0);
    chk("rst_wdata", 32'(mwd[0]), 32'd0);
    clear_inputs();
    sb_en = 1'b1;

    // instance 0: zero-wait access, round-robin, lock
    tbl.push_back(mk(0, 6'b100000, 10'h005, 10'h000, 16'h0000, 16'h0000, 2'b10, 1'b1));
    tbl.push_back(mk(0, 6'b000000, 10'h000, 10'h000, 16'h0000, 16'h0000, 2'b00, 1'b0));
    tbl.push_back(mk(0, 6'b010100, 10'h000, 10'h3FF, 16'h0000, 16'hBEEF, 2'b01, 1'b0));
    tbl.push_back(mk(0, 6'b100000, 10'h3FF, 10'h000, 16'h0000, 16'h0000, 2'b10, 1'b0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 6'b111100, 10'h010, 10'h020, 16'hA000, 16'hB000,
                       (i % 2 == 0) ? 2'b10 : 2'b01, i == 0));
    tbl.push_back(mk(0, 6'b100000, 10'h010, 10'h000, 16'h0000, 16'h0000, 2'b10, 1'b0));
    tbl.push_back(mk(0, 6'b010000, 10'h000, 10'h020, 16'h0000, 16'h0000, 2'b01, 1'b0));
    tbl.push_back(mk(0, 6'b110000, 10'h010, 10'h020, 16'h0000, 16'h0000, 2'b10, 1'b0));
    tbl.push_back(mk(0, 6'b110000, 10'h010, 10'h020, 16'h0000, 16'h0000, 2'b01, 1'b0));
    tbl.push_back(mk(0, 6'b000000, 10'h000, 10'h000, 16'h0000, 16'h0000, 2'b00, 1'b0));
    tbl.push_back(mk(0, 6'b101000, 10'h030, 10'h000, 16'h1111, 16'h0000, 2'b10, 1'b0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 6'b111101, 10'h030, 10'h040, 16'h1111, 16'h2222, 2'b01, 1'b0));
    tbl.push_back(mk(0, 6'b111100, 10'h030, 10'h040, 16'h3333, 16'h4444, 2'b10, 1'b0));
    tbl.push_back(mk(0, 6'b111100, 10'h030, 10'h040, 16'h3333, 16'h4444, 2'b01, 1'b0));
    tbl.push_back(mk(0, 6'b100000, 10'h040, 10'h000, 16'h0000, 16'h0000, 2'b10, 1'b0));
    tbl.push_back(mk(0, 6'b000000, 10'h000, 10'h000, 16'h0000, 16'h0000, 2'b00, 1'b0));

    // instance 1 (MAX_WAIT=3): starvation breaks requester 1's lock
    tbl.push_back(mk(1, 6'b100000, 10'h005, 10'h000, 16'h0000, 16'h0000, 2'b10, 1'b1));
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(1, 6'b110001, 10'h005, 10'h010, 16'h0000, 16'h0000,
                       (i == 3) ? 2'b10 : 2'b01, 1'b0));
    tbl.push_back(mk(1, 6'b000000, 10'h000, 10'h000, 16'h0000, 16'h0000, 2'b00, 1'b0));

    // instance 2 (MAX_WAIT=4, fixed priority): one forced gnt1 every fifth cycle
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(2, 6'b110000, 10'h005, 10'h010, 16'h0000, 16'h0000,
                       (i == 4 || i == 9) ? 2'b01 : 2'b10, i == 0));
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(2, 6'b110010, 10'h005, 10'h010, 16'h0000, 16'h0000,
                       (i == 4) ? 2'b01 : 2'b10, i == 0));
    tbl.push_back(mk(2, 6'b000000, 10'h000, 10'h000, 16'h0000, 16'h0000, 2'b00, 1'b0));

    foreach (tbl[i]) begin
      if (tbl[i].rb) do_reset();
      apply(tbl[i]);
    end

    // Reset asserted while a granted read is in flight
    do_reset();
    @(negedge clk);
    cur = 0;
    req0 = 1; we0 = 0; addr0 = 10'h005;
    #4;
    chk("midrd_gnt0", 32'(g0[0]), 32'd1);
    chk("midrd_raddr", 32'(mra[0]), 32'h005);
    rst = 1'b0;
    @(posedge clk);
    #2;
    chk("midrd_rvalid0", 32'(rv0[0]), 32'd0);
    chk("midrd_gnt0_rst", 32'(g0[0]), 32'd0);
    chk("midrd_mem_we", 32'(mwe[0]), 32'd0);
    chk("midrd_waddr", 32'(mwa[0]), 32'd0);
    chk("midrd_raddr_rst", 32'(mra[0]), 32'd0);
    chk("midrd_wdata", 32'(mwd[0]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    req0 = 0; req1 = 1; we1 = 0; addr1 = 10'h3FF;
    #4;
    chk("post_rst_gnt1", 32'(g1[0]), 32'd1);
    chk("post_rst_gnt0", 32'(g0[0]), 32'd0);
    chk("post_rst_raddr", 32'(mra[0]), 32'h3FF);
    q1.push_back(exp_mem[10'h3FF]);
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 8, meaning: cycles a requester may be denied before it is forced to win; legal range 2..15.
REQ-002 Parameter PRIO_MODE, default 0, meaning: 0 = round-robin, 1 = fixed priority with requester 0 highest.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req0, req1  input  1 each  access request from requester 0 (CPU core) and requester 1 (loader/debug port).
REQ-006 we0, we1  input  1 each  1 = write, 0 = read; valid while reqN is high.
REQ-007 lock0, lock1  input  1 each  hold ownership across consecutive accesses; valid while reqN is high.
REQ-008 addr0, addr1  input  10 each  word address.
REQ-009 wdata0, wdata1  input  16 each  write data.
REQ-010 gnt0, gnt1  output  1 each  access accepted this cycle; combinational.
REQ-011 rvalid0, rvalid1  output  1 each  read data valid this cycle; registered.
REQ-012 rdata0, rdata1  output  16 each  read data; equals mem_rdata.
REQ-013 mem_we  output  1  memory write enable.
REQ-014 mem_waddr, mem_raddr  output  10 each  memory write and read addresses.
REQ-015 mem_wdata  output  16  memory write data.
REQ-016 mem_rdata  input  16  memory read data; valid the cycle after mem_raddr is issued.

Function
REQ-017 At most one of gnt0/gnt1 is high in any cycle; a grant is never given to a requester whose reqN is low.
REQ-018 A granted cycle drives the winner's address to mem_waddr and mem_raddr, and wdataN to mem_wdata; mem_we = weN & gntN; with no grant, mem_we = 0 and the addresses hold their last value.
REQ-019 For a granted read, rvalidN is high exactly one cycle later, with rdataN = mem_rdata; rvalidN is low in all other cycles.
REQ-020 The state machine has three states: IDLE, OWN0 and OWN1.
  - OWNn is entered after a granted cycle with lockn = 1.
  - The block stays in OWNn while reqn & lockn.
  - It returns to IDLE when reqn or lockn drops; the grant in that cycle is decided by IDLE rules.
REQ-021 In OWNn, requester n is granted every cycle it requests, unless the other requester is starving (REQ-024).
REQ-022 IDLE with a single requester: that requester is granted in the same cycle (zero-wait).
REQ-023 IDLE with both requesting:
  - PRIO_MODE=0: the requester not granted most recently wins; a last-grant pointer updates on every grant.
  - PRIO_MODE=1: requester 0 wins.
REQ-024 Each requester has a 4-bit wait counter:
  - It increments on each cycle with reqN & ~gntN, saturating at MAX_WAIT.
  - It clears on gntN or ~reqN.
  - When waitN == MAX_WAIT, requester N wins the next cycle it requests, overriding PRIO_MODE and any lock held by the other requester; that lock is then broken and the state goes to IDLE (or to OWNN if lockN is set).
REQ-025 If both wait counters equal MAX_WAIT, requester 0 wins.
REQ-026 Requests and sideband signals are sampled only in the grant cycle; a requester that drops reqN before a grant loses nothing and causes no memory access.

Reset
REQ-027 While rst is low, the block shall hold:
  - state IDLE; last-grant pointer = 1 (requester 0 wins the first contention);
  - wait counters 0; rvalid0 = rvalid1 = 0;
  - mem_we = 0; mem_waddr = mem_raddr = 0; mem_wdata = 0.
REQ-028 Assertion of rst mid-read suppresses the pending rvalid; the first grant after deassertion follows IDLE rules.

Verification
REQ-029 Reset, then req0 read at addr 0x005 with memory holding 0x1234 -> gnt0 = 1 that cycle, rvalid0 = 1 and rdata0 = 0x1234 next cycle.
REQ-030 PRIO_MODE=0, req0 and req1 held high for 4 cycles (writes) -> grants alternate 0,1,0,1 and mem_we = 1 each cycle.
REQ-031 req1 with lock1 held 5 cycles while req0 is also high -> gnt1 for 5 cycles, then gnt0 in cycle 6.
REQ-032 MAX_WAIT=3, req1+lock1 and req0 held continuously -> gnt1 in cycles 1-3, gnt0 forced in cycle 4, state leaves OWN1.
REQ-033 PRIO_MODE=1, both request continuously -> gnt0 only until wait1 = MAX_WAIT, then exactly one gnt1, then back to gnt0.
REQ-034 rst pulled low in the cycle after a granted read -> rvalid0 stays 0, all outputs at reset values, next req1 after release is granted immediately.
